sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_pkg.sv | 30 +++
 rtl/fifo_ob2.sv | 58 +++++
 rtl/sram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
// SRAM geometry, data width, counter widths and the output-buffer depth
// live here so the controller and its output buffer agree on them.
package sram_fifo_pkg;

  localparam int unsigned SRAM_DEPTH = 32;   // SRAM words
  localparam int unsigned DATA_WIDTH = 12;   // data bits per word
  localparam int unsigned ADDR_W     = 5;    // SRAM address width
  localparam int unsigned CNT_W      = 6;    // total occupancy width (0..34)
  localparam int unsigned OB_DEPTH   = 2;    // output-buffer entries
  localparam int unsigned OB_CNT_W   = 2;    // output-buffer level width

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [OB_CNT_W-1:0] ob_cnt_t;

  // Drive bundle for one SRAM port.
  typedef struct packed {
    logic  cs;
    logic  we_n;
    addr_t addr;
  } port_ctl_t;

  // Circular pointer advance for a memory of 'depth' words.
  function automatic addr_t ptr_inc(input addr_t p, input int unsigned depth);
    if (p == addr_t'(depth - 1)) return '0;
    return p + addr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_ob2.sv
// Two-entry output buffer sitting between the SRAM read port and the
// consumer. The head entry is always held in 'head' so the output is
// registered and stable while not popped.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset (clears data and level)
//   clear  - synchronous flush (clears level only), overrides push/pop
//   push   - store din this cycle
//   pop    - drop the head entry this cycle (only when count > 0)
//   din    - captured word
//   dout   - head entry
//   count  - number of held entries (0..2)
module fifo_ob2
  import sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output ob_cnt_t          count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  ob_cnt_t          level;
  logic             to_head;

  // After an optional pop the incoming word lands in the first free slot;
  // that slot is the head exactly when level equals pop.
  assign to_head = (level == ob_cnt_t'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else if (clear) begin
      level <= '0;
    end else begin
      level <= level + ob_cnt_t'(push) - ob_cnt_t'(pop);
      if (pop) head <= tail;
      // A push into the head slot must win over the shift above.
      if (push) begin
        if (to_head) head <= din;
        else         tail <= din;
      end
    end
  end

  assign dout  = head;
  assign count = level;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller storing words in an external dual-port SRAM (one read
// port, one write port, 1-cycle read latency) with a two-entry registered
// output buffer. Total capacity is the SRAM depth plus the read in flight
// and the output buffer.
// Ports:
//   CK, RST, FLUSH          - clock, sync active-high reset, sync flush
//   IN_VALID/IN_READY/IN_DATA    - producer handshake
//   OUT_VALID/OUT_READY/OUT_DATA - consumer handshake (OUT_DATA registered)
//   MEM_A, MEM_CSA, MEM_OE, MEM_DO - SRAM read port
//   MEM_B, MEM_CSB, MEM_WEB, MEM_DI - SRAM write port
//   COUNT                   - registered total words held
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = SRAM_DEPTH,
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WIDTH-1:0]  IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  OUT_DATA,
  output logic [ADDR_W-1:0] MEM_A,
  output logic              MEM_CSA,
  output logic              MEM_OE,
  input  logic [WIDTH-1:0]  MEM_DO,
  output logic [ADDR_W-1:0] MEM_B,
  output logic              MEM_CSB,
  output logic              MEM_WEB,
  output logic [WIDTH-1:0]  MEM_DI,
  output logic [CNT_W-1:0]  COUNT
);

  addr_t     wr_ptr;
  addr_t     rd_ptr;
  cnt_t      mem_count;
  cnt_t      mem_count_nxt;
  cnt_t      count_q;
  logic      rd_pending;
  ob_cnt_t   ob_count;
  ob_cnt_t   ob_count_nxt;
  logic      hold;
  logic      push;
  logic      pop;
  logic      rd_issue;
  logic [2:0] ob_inflight;
  port_ctl_t wport;
  port_ctl_t rport;

  assign hold     = RST | FLUSH;
  assign IN_READY = (mem_count < cnt_t'(DEPTH)) && !hold;
  assign push     = IN_VALID && IN_READY;
  assign pop      = OUT_VALID && OUT_READY;

  // Buffer slots committed once this cycle's pop leaves; a new read may only
  // be issued if its data is guaranteed a slot when it returns next cycle.
  assign ob_inflight = {1'b0, ob_count} + {2'b00, rd_pending} - {2'b00, pop};
  assign rd_issue    = (mem_count != '0) && (ob_inflight < 3'(OB_DEPTH)) && !hold;

  always_comb begin
    wport.cs   = push;
    wport.we_n = !push;
    wport.addr = wr_ptr;
    rport.cs   = rd_issue;
    rport.we_n = 1'b1;
    rport.addr = rd_ptr;
  end

  assign MEM_CSB = wport.cs;
  assign MEM_WEB = wport.we_n;
  assign MEM_B   = wport.addr;
  assign MEM_DI  = IN_DATA;
  assign MEM_CSA = rport.cs;
  assign MEM_A   = rport.addr;
  assign MEM_OE  = 1'b1;

  always_comb begin
    mem_count_nxt = mem_count;
    case ({push, rd_issue})
      2'b10:   mem_count_nxt = mem_count + cnt_t'(1);
      2'b01:   mem_count_nxt = mem_count - cnt_t'(1);
      default: mem_count_nxt = mem_count;
    endcase
    ob_count_nxt = ob_count + ob_cnt_t'(rd_pending) - ob_cnt_t'(pop);
  end

  always_ff @(posedge CK) begin
    if (hold) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
      count_q    <= '0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr, DEPTH);
      if (rd_issue) rd_ptr <= ptr_inc(rd_ptr, DEPTH);
      mem_count  <= mem_count_nxt;
      rd_pending <= rd_issue;
      count_q    <= mem_count_nxt + cnt_t'(rd_issue) + cnt_t'(ob_count_nxt);
    end
  end

  // Returning read data is captured unconditionally when pending; a flush
  // clears the buffer and rd_pending together, discarding it.
  fifo_ob2 #(.WIDTH(WIDTH)) u_ob (
    .clk   (CK),
    .rst   (RST),
    .clear (FLUSH),
    .push  (rd_pending),
    .pop   (pop),
    .din   (MEM_DO),
    .dout  (OUT_DATA),
    .count (ob_count)
  );

  assign OUT_VALID = (ob_count != '0);
  assign COUNT     = count_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: behavioural SRAM, queue-based
// reference model and a negedge monitor that scores every handshake.
module tb_sram_fifo_ctrl;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [11:0] IN_DATA = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [11:0] OUT_DATA;
  logic [4:0]  MEM_A;
  logic        MEM_CSA;
  logic        MEM_OE;
  logic [11:0] MEM_DO = '0;
  logic [4:0]  MEM_B;
  logic        MEM_CSB;
  logic        MEM_WEB;
  logic [11:0] MEM_DI;
  logic [5:0]  COUNT;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] sram[32];
  logic armed = 1'b0;

  always #5 CK = ~CK;

  sram_fifo_ctrl #(.DEPTH(32), .WIDTH(12)) dut (
    .CK(CK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .MEM_A(MEM_A), .MEM_CSA(MEM_CSA), .MEM_OE(MEM_OE), .MEM_DO(MEM_DO),
    .MEM_B(MEM_B), .MEM_CSB(MEM_CSB), .MEM_WEB(MEM_WEB), .MEM_DI(MEM_DI),
    .COUNT(COUNT)
  );

  // 32x12 SRAM, one read and one write port, 1-cycle read latency.
  always @(posedge CK) begin
    if (MEM_CSB && !MEM_WEB) sram[MEM_B] <= MEM_DI;
    if (MEM_CSA && MEM_OE) MEM_DO <= sram[MEM_A];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: model occupancy is the queue size; words enter on an accepted
  // push and must leave in the same order on an accepted pop.
  always @(negedge CK) begin
    logic [11:0] w;
    if (armed) begin
      chk("count_model", COUNT, exp_q.size());
      if (RST || FLUSH) chk("in_ready_hold", IN_READY, 0);
      else if (exp_q.size() <= 31) chk("in_ready_room", IN_READY, 1);
      else if (exp_q.size() >= 34) chk("in_ready_full", IN_READY, 0);
      if (exp_q.size() == 0) chk("out_valid_empty", OUT_VALID, 0);
      chk("mem_write_on_accept", MEM_CSB, IN_VALID && IN_READY);
    end
    if (RST || FLUSH) begin
      exp_q.delete();
      armed = 1'b1;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_on_empty: got 0x%0h expected no word", OUT_DATA);
        end else begin
          w = exp_q.pop_front();
          chk("out_data_order", OUT_DATA, w);
        end
      end
      if (IN_VALID && IN_READY) exp_q.push_back(IN_DATA);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic push_word(input logic [11:0] d);
    int n;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    for (n = 0; n < 50; n++) begin
      #1;
      if (IN_READY) break;
      step();
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL push_accept: got no IN_READY expected accept of 0x%0h", d);
    end
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    for (n = 0; n < 200; n++) begin
      #1;
      if (COUNT == 0) break;
      step();
    end
    chk("drain_empty", COUNT, 0);
    step();
  endtask

  initial begin
    int acc;
    int ov;
    logic [11:0] d;
    for (int i = 0; i < 32; i++) sram[i] = '0;

    // Reset
    step(); step(); step();
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_csa", MEM_CSA, 0);
    chk("rst_csb", MEM_CSB, 0);
    chk("rst_web", MEM_WEB, 1);
    chk("mem_oe", MEM_OE, 1);
    step();
    RST = 1'b0;

    // Single-word latency: write, read, capture
    IN_VALID = 1'b1; IN_DATA = 12'h0A5; OUT_READY = 1'b1;
    #1;
    chk("lat_in_ready", IN_READY, 1);
    chk("lat_csb", MEM_CSB, 1);
    chk("lat_web", MEM_WEB, 0);
    chk("lat_b", MEM_B, 0);
    chk("lat_di", MEM_DI, 12'h0A5);
    step();
    IN_VALID = 1'b0;
    #1;
    chk("lat_c1_csa", MEM_CSA, 1);
    chk("lat_c1_a", MEM_A, 0);
    chk("lat_c1_count", COUNT, 1);
    chk("lat_c1_valid", OUT_VALID, 0);
    step(); #1;
    chk("lat_c2_valid", OUT_VALID, 0);
    step(); #1;
    chk("lat_c3_valid", OUT_VALID, 1);
    chk("lat_c3_data", OUT_DATA, 12'h0A5);
    step(); #1;
    chk("lat_c4_count", COUNT, 0);
    step();

    // Fill to 34 with consumer stalled
    OUT_READY = 1'b0;
    for (int i = 0; i < 34; i++) push_word(12'(i));
    #1;
    chk("full_in_ready", IN_READY, 0);
    step(); #1;
    chk("full_count", COUNT, 34);
    chk("full_csa_idle", MEM_CSA, 0);
    chk("full_head", OUT_DATA, 12'h000);
    step();
    IN_VALID = 1'b1; IN_DATA = 12'h022;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_drop_csb", MEM_CSB, 0);
      chk("full_drop_csa", MEM_CSA, 0);
      step();
    end
    #1;
    chk("full_hold_count", COUNT, 34);
    chk("full_hold_data", OUT_DATA, 12'h000);
    step();

    // Full-rate streaming from full, pointers wrap
    acc = 0; ov = 0; d = 12'h100;
    IN_VALID = 1'b1; IN_DATA = d; OUT_READY = 1'b1;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (IN_READY) acc++;
      if (OUT_VALID) ov++;
      step();
      if (IN_READY || acc > 0) begin
        d = 12'h100 + 12'(acc);
        IN_DATA = d;
      end
    end
    chk("stream_accepts", acc, 79);
    chk("stream_out_cycles", ov, 80);
    IN_VALID = 1'b0;
    wait_empty();

    // Flush with a read in flight
    OUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) push_word(12'h200 + 12'(i));
    step(); step(); step();
    #1;
    chk("flush_pre_count", COUNT, 10);
    step();
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 12'h777;
    #1;
    chk("flush_setup_read", MEM_CSA, 1);
    step();
    OUT_READY = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b1;
    #1;
    chk("flush_cycle_count", COUNT, 10);
    step();
    FLUSH = 1'b0;
    #1;
    chk("flush_count", COUNT, 0);
    chk("flush_valid", OUT_VALID, 0);
    IN_VALID = 1'b1; IN_DATA = 12'h3C3; OUT_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    #1;
    chk("flush_c1_valid", OUT_VALID, 0);
    step(); step(); #1;
    chk("flush_c3_valid", OUT_VALID, 1);
    chk("flush_c3_data", OUT_DATA, 12'h3C3);
    step(); #1;
    chk("flush_c4_count", COUNT, 0);
    step();

    // Reset mid-stream
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) push_word(12'h400 + 12'(i));
    step(); step(); step();
    #1;
    chk("rst_mid_pre_count", COUNT, 5);
    step();
    RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 12'h5A5;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_mid_in_ready", IN_READY, 0);
      chk("rst_mid_csb", MEM_CSB, 0);
      chk("rst_mid_web", MEM_WEB, 1);
      chk("rst_mid_csa", MEM_CSA, 0);
      step();
      #1;
      chk("rst_mid_valid", OUT_VALID, 0);
      chk("rst_mid_data", OUT_DATA, 0);
      chk("rst_mid_count", COUNT, 0);
      step();
    end
    RST = 1'b0; IN_VALID = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      IN_VALID  = 1'($urandom_range(0, 1));
      IN_DATA   = 12'($urandom);
      OUT_READY = 1'($urandom_range(0, 1));
      step();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    wait_empty();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
